npu_inst_issuer: RTL

NPU_INST_ISSUER -- requirements
Module: npu_inst_issuer

---
 rtl/npu_inst_issuer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/npu_inst_issuer.sv
// npu_inst_issuer: fetches 128-bit instructions as 8 x 16-bit SRAM words and issues them to the NPU.
// Latency: 2 cycles per word (one read outstanding), then WAIT_RDY -> ISSUE -> GAP_CYCLES idle per instruction.
// Backpressure: holds in WAIT_RDY until npu_inst_ready; optional watchdog via `NPU_ISSUER_TIMEOUT_EN` (adds error).
module npu_inst_issuer #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [19:0]  base_addr,
  input  logic [10:0]  inst_count,
  output logic         sram_rd_en,
  output logic [19:0]  sram_addr,
  input  logic [15:0]  sram_rd_data,
  input  logic         sram_rd_valid,
  output logic [127:0] npu_inst,
  output logic         npu_inst_en,
  input  logic         npu_inst_ready,
  output logic         busy,
  output logic         done
`ifdef NPU_ISSUER_TIMEOUT_EN
  ,
  output logic         error
`endif
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_RDY, ISSUE, GAP, DRAIN_LO, DRAIN_HI, FINISH
  } state_t;

  // GAP_CYCLES of 0 or 1 both give a single GAP cycle.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t             state_q, state_d;
  logic               rd_pend;     // a read has been requested and its data not yet taken
  logic [2:0]         word_cnt;    // word index inside the current instruction
  logic [111:0]       inst_buf;    // words 0..6 collect here so npu_inst stays stable until the fetch completes
  logic [10:0]        inst_left;   // instructions not yet issued
  logic [GAP_W-1:0]   gap_cnt;
  logic               word_ok;
  logic               gap_last;
  logic               wd_expire;

  // The cycle carrying rd_en can never carry the matching data, and valid without a pending read is stray.
  assign word_ok  = (state_q == FETCH) && rd_pend && !sram_rd_en && sram_rd_valid;
  assign gap_last = (GAP_CYCLES <= 1) || (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  assign npu_inst_en = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);

`ifdef NPU_ISSUER_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;

  assign wd_active = (state_q == WAIT_RDY) || (state_q == DRAIN_LO) || (state_q == DRAIN_HI);
  assign wd_expire = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts consecutive cycles spent waiting on the executor, cleared whenever not waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (!wd_active) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Sticky error: set on watchdog expiry, cleared only by reset or the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error <= 1'b0;
    end else if (state_q == IDLE && start) begin
      error <= 1'b0;
    end else if (wd_expire) begin
      error <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign wd_expire      = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; watchdog expiry overrides any waiting state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = (inst_count == 11'd0) ? FINISH : FETCH;
      FETCH:    if (word_ok && word_cnt == 3'd7) state_d = WAIT_RDY;
      WAIT_RDY: if (npu_inst_ready) state_d = ISSUE;
      ISSUE:    state_d = GAP;
      GAP:      if (gap_last) state_d = (inst_left != 11'd0) ? FETCH : DRAIN_LO;
      DRAIN_LO: if (!npu_inst_ready) state_d = DRAIN_HI;
      DRAIN_HI: if (npu_inst_ready) state_d = FINISH;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (wd_expire) begin
      state_d = FINISH;
    end
  end

  // Datapath: read sequencing, word assembly, instruction/gap counting and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_rd_en <= 1'b0;
      sram_addr  <= '0;
      rd_pend    <= 1'b0;
      word_cnt   <= '0;
      inst_buf   <= '0;
      npu_inst   <= '0;
      inst_left  <= '0;
      gap_cnt    <= '0;
      done       <= 1'b0;
    end else begin
      sram_rd_en <= 1'b0;
      done       <= (state_q == FINISH);
      gap_cnt    <= (state_q == GAP) ? gap_cnt + 1'b1 : '0;

      if (state_q == IDLE && start) begin
        sram_addr <= base_addr;
        inst_left <= inst_count;
        word_cnt  <= '0;
        rd_pend   <= 1'b0;
      end

      if (state_q == FETCH) begin
        if (!rd_pend) begin
          sram_rd_en <= 1'b1;
          rd_pend    <= 1'b1;
        end else if (word_ok) begin
          // sram_addr wraps naturally at 20 bits; the next read goes out on the same edge.
          inst_buf  <= {inst_buf[95:0], sram_rd_data};
          sram_addr <= sram_addr + 20'd1;
          word_cnt  <= word_cnt + 3'd1;
          if (word_cnt == 3'd7) begin
            npu_inst <= {inst_buf, sram_rd_data};
            rd_pend  <= 1'b0;
          end else begin
            sram_rd_en <= 1'b1;
          end
        end
      end

      if (state_q == ISSUE) begin
        inst_left <= inst_left - 11'd1;
      end
    end
  end

endmodule
